// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, fault causes, FSM states.
package lsu_pkg;

  localparam int unsigned XLEN = 64;

  // RV64I load/store funct3 encodings
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_RANGE    = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STORE = 3'd1,
    LOAD  = 3'd2,
    LWAIT = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  // Request fields kept after acceptance for the load return path
  typedef struct packed {
    logic [2:0] funct3;
    logic [2:0] offset;
  } lsu_req_lat_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and memory-port bundle for the load/store unit.
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = 10
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct3;
  logic [XLEN-1:0]         req_addr;
  logic [WIDTH-1:0]        req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [WIDTH-1:0]        resp_rdata;
  logic                    resp_err;
  logic [1:0]              resp_cause;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH/8-1:0]      mem_we;
  logic                    mem_re;
  logic [WIDTH-1:0]        mem_rdata;

  // Requester side: issues requests, consumes responses, provides memory
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
           mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load return path: lane shift of the memory word, then sign/zero extension.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [2:0]       funct3,
  input  logic [2:0]       offset,
  output logic [WIDTH-1:0] ext_data_c
);

  logic [WIDTH-1:0] lane_c;

  // Bring the addressed byte lane down to bit 0 and extend per access type
  always_comb begin
    lane_c = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    ext_data_c = {{(WIDTH-8){lane_c[7]}},   lane_c[7:0]};
      F3_H:    ext_data_c = {{(WIDTH-16){lane_c[15]}}, lane_c[15:0]};
      F3_W:    ext_data_c = {{(WIDTH-32){lane_c[31]}}, lane_c[31:0]};
      F3_D:    ext_data_c = lane_c;
      F3_BU:   ext_data_c = {{(WIDTH-8){1'b0}},  lane_c[7:0]};
      F3_HU:   ext_data_c = {{(WIDTH-16){1'b0}}, lane_c[15:0]};
      F3_WU:   ext_data_c = {{(WIDTH-32){1'b0}}, lane_c[31:0]};
      default: ext_data_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: fault screening, byte-lane store, load with extension.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned HI = ADDR_WIDTH + 3;

  lsu_state_e            state_q, state_d;
  lsu_req_lat_t          lat_q, lat_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]      resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  cause_e                resp_cause_q, resp_cause_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]         mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;

  logic [2:0]            off_c;
  logic                  illegal_c, misalign_c, range_c;
  cause_e                cause_c;
  logic [NB-1:0]         mask_c;
  logic [WIDTH-1:0]      ext_c;

  lsu_load_extend #(.WIDTH(WIDTH)) u_extend (
    .rdata      (bus.mem_rdata),
    .funct3     (lat_q.funct3),
    .offset     (lat_q.offset),
    .ext_data_c (ext_c)
  );

  // Classify the offered request: fault cause in priority order and store byte mask
  always_comb begin
    off_c      = bus.req_addr[2:0];
    illegal_c  = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == F3_ILL);
    misalign_c = 1'b0;
    mask_c     = '0;
    case (bus.req_funct3[1:0])
      2'd0: begin misalign_c = 1'b0;             mask_c = NB'(8'h01); end
      2'd1: begin misalign_c = off_c[0];         mask_c = NB'(8'h03); end
      2'd2: begin misalign_c = |off_c[1:0];      mask_c = NB'(8'h0F); end
      default: begin misalign_c = |off_c;        mask_c = NB'(8'hFF); end
    endcase
    range_c = |(bus.req_addr >> HI);
    if (illegal_c)       cause_c = CAUSE_ILLEGAL;
    else if (misalign_c) cause_c = CAUSE_MISALIGN;
    else if (range_c)    cause_c = CAUSE_RANGE;
    else                 cause_c = CAUSE_NONE;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_cause_d = resp_cause_q;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_we_d     = '0;
    mem_re_d     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          req_ready_d  = 1'b0;
          lat_d.funct3 = bus.req_funct3;
          lat_d.offset = off_c;
          if (cause_c != CAUSE_NONE) begin
            // Faulted requests never touch memory
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            resp_cause_d = cause_c;
          end else begin
            mem_addr_d = bus.req_addr[HI-1:3];
            if (bus.req_we) begin
              state_d     = STORE;
              mem_wdata_d = bus.req_wdata << {off_c, 3'b000};
              mem_we_d    = mask_c << off_c;
            end else begin
              state_d  = LOAD;
              mem_re_d = 1'b1;
            end
          end
        end
      end
      STORE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        resp_cause_d = CAUSE_NONE;
      end
      LOAD: begin
        state_d = LWAIT;
      end
      LWAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ext_c;
        resp_err_d   = 1'b0;
        resp_cause_d = CAUSE_NONE;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          resp_cause_d = CAUSE_NONE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= '0;
      mem_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_cause_q <= resp_cause_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_cause = resp_cause_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_re     = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-level reference memory model.
module tb_load_store_unit;

  localparam int unsigned W  = 64;
  localparam int unsigned AW = 10;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  load_store_unit_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  load_store_unit #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory attached to the DUT, and the reference view of the same bytes
  logic [63:0] mem [0:1023];
  logic [63:0] rd_q;
  logic [7:0]  refb [0:8191];

  assign bus.mem_rdata = rd_q;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [1:0]  cause;
    int          lat;
    int          acc;
    logic        st;
    logic        ld;
    logic [9:0]  maddr;
    logic [7:0]  we;
    logic [63:0] wdata;
    logic        hit;
  } exp_t;

  exp_t sb[$];

  logic        seen;
  logic [63:0] snap_rdata;
  logic [2:0]  snap_ec;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: read data one cycle after mem_re, byte-enabled writes
  always @(posedge clk) begin
    if (bus.mem_re) rd_q <= mem[bus.mem_addr];
    for (int b = 0; b < 8; b++)
      if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour straight from the access rules; stores update the byte model
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wd);
    exp_t        e;
    int          nb;
    int          off;
    int          base;
    logic [63:0] v;
    e = '{default: 0};
    nb = 1 << f3[1:0];
    if (we ? f3[2] : (f3 == 3'b111)) e.cause = 2'd2;
    else if ((addr % 64'(nb)) != 64'd0) e.cause = 2'd1;
    else if (addr >= 64'h2000) e.cause = 2'd3;
    if (e.cause != 2'd0) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    off     = int'(addr[2:0]);
    base    = int'(addr[12:0]);
    e.maddr = 10'(addr / 64'd8);
    if (we) begin
      e.st    = 1'b1;
      e.lat   = 2;
      e.we    = 8'(((1 << nb) - 1) << off);
      e.wdata = wd << (8 * off);
      for (int i = 0; i < nb; i++) refb[base + i] = wd[8*i +: 8];
    end else begin
      e.ld  = 1'b1;
      e.lat = 3;
      v = 64'd0;
      for (int i = 0; i < nb; i++) v = v | (64'(refb[base + i]) << (8 * i));
      if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      e.rdata = v;
    end
    return e;
  endfunction

  // Monitor: memory-port activity and responses checked against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      seen = 1'b0;
    end else begin
      if (bus.mem_we != '0) begin
        if (sb.size() == 0 || !sb[0].st) chk("stray_mem_we", 64'(bus.mem_we), 64'd0);
        else begin
          chk("store_cycle", 64'(cyc - sb[0].acc), 64'd1);
          chk("store_addr", 64'(bus.mem_addr), 64'(sb[0].maddr));
          chk("store_we", 64'(bus.mem_we), 64'(sb[0].we));
          chk("store_wdata", bus.mem_wdata, sb[0].wdata);
          sb[0].hit = 1'b1;
        end
      end
      if (bus.mem_re) begin
        if (sb.size() == 0 || !sb[0].ld) chk("stray_mem_re", 64'(bus.mem_re), 64'd0);
        else begin
          chk("load_cycle", 64'(cyc - sb[0].acc), 64'd1);
          chk("load_addr", 64'(bus.mem_addr), 64'(sb[0].maddr));
          sb[0].hit = 1'b1;
        end
      end
      if (bus.resp_valid) begin
        if (sb.size() == 0) chk("stray_resp_valid", 64'(bus.resp_valid), 64'd0);
        else begin
          if (!seen) begin
            chk("resp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            seen       = 1'b1;
            snap_rdata = bus.resp_rdata;
            snap_ec    = {bus.resp_err, bus.resp_cause};
          end else begin
            chk("hold_rdata", bus.resp_rdata, snap_rdata);
            chk("hold_err_cause", 64'({bus.resp_err, bus.resp_cause}), 64'(snap_ec));
          end
          if (bus.resp_ready) begin
            chk("resp_rdata", bus.resp_rdata, sb[0].rdata);
            chk("resp_err", 64'(bus.resp_err), 64'(sb[0].err));
            chk("resp_cause", 64'(bus.resp_cause), 64'(sb[0].cause));
            if (sb[0].st || sb[0].ld) chk("mem_access_seen", 64'(sb[0].hit), 64'd1);
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_reset(input string t);
    chk({t, "_req_ready"},  64'(bus.req_ready),  64'd1);
    chk({t, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({t, "_resp_rdata"}, bus.resp_rdata,      64'd0);
    chk({t, "_resp_err"},   64'(bus.resp_err),   64'd0);
    chk({t, "_resp_cause"}, 64'(bus.resp_cause), 64'd0);
    chk({t, "_mem_we"},     64'(bus.mem_we),     64'd0);
    chk({t, "_mem_re"},     64'(bus.mem_re),     64'd0);
    chk({t, "_mem_addr"},   64'(bus.mem_addr),   64'd0);
    chk({t, "_mem_wdata"},  bus.mem_wdata,       64'd0);
  endtask

  // One transaction: offer, push expectation on accept, then drain the response
  task automatic xact(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wd, input int stall, input bit poke);
    exp_t e;
    int   n;
    int   st;
    bus.resp_ready = (stall == 0);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_at_issue", 64'(bus.req_ready), 64'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    e     = model(we, f3, addr, wd);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n  = 0;
    st = 0;
    while (sb.size() != 0 && n < 50) begin
      if (bus.resp_valid) begin
        if (st >= stall) begin
          bus.resp_ready = 1'b1;
          bus.req_valid  = 1'b0;
        end else begin
          bus.resp_ready = 1'b0;
          st++;
          if (poke) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'b011;
            bus.req_addr   = 64'd0;
            bus.req_wdata  = 64'd0;
            chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
          end
        end
      end
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (sb.size() != 0) begin
      chk("resp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [63:0] w0;
    logic [63:0] a;
    logic [2:0]  f3;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    bus.resp_ready = 1'b0;
    for (int w = 0; w < 1024; w++) mem[w] = {$urandom, $urandom};
    mem[0] = 64'hDEADBEEF12345678;
    mem[1] = 64'hCAFEBABE87654321;
    for (int i = 0; i < 8192; i++) refb[i] = mem[i / 8][8*(i % 8) +: 8];

    #2 rst = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Directed accesses on the preloaded words
    xact(1'b1, 3'b000, 64'h5, 64'hAA, 0, 1'b0);
    xact(1'b0, 3'b000, 64'h4, 64'h0, 0, 1'b0);
    xact(1'b0, 3'b100, 64'h4, 64'h0, 1, 1'b0);
    xact(1'b0, 3'b010, 64'hC, 64'h0, 0, 1'b0);
    xact(1'b0, 3'b110, 64'hC, 64'h0, 2, 1'b0);
    xact(1'b0, 3'b011, 64'h8, 64'h0, 0, 1'b0);
    xact(1'b0, 3'b001, 64'h3, 64'h0, 0, 1'b0);
    xact(1'b0, 3'b111, 64'h0, 64'h0, 0, 1'b0);
    xact(1'b1, 3'b011, 64'h2000, 64'h1234, 0, 1'b0);
    xact(1'b0, 3'b011, 64'h8, 64'h0, 3, 1'b1);

    // Reset lands in the STORE cycle of an SD: nothing may be written
    for (int i = 0; i < 8; i++) w0[8*i +: 8] = refb[i];
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = '1;
    chk("abort_accept_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("abort_store_we", 64'(bus.mem_we), 64'hFF);
    rst = 1'b0;
    #1 check_reset("abort");
    @(posedge clk); #1;
    chk("abort_word0", mem[0], w0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomized mix of loads, stores and faults
    for (int k = 0; k < 150; k++) begin
      f3 = 3'($urandom % 8);
      a  = 64'($urandom_range(0, 8191));
      if ($urandom % 10 == 0) a = a | (64'd1 << (13 + $urandom % 51));
      if ($urandom % 2 == 0) a = a & ~64'((1 << f3[1:0]) - 1);
      xact(1'($urandom % 2), f3, a, {$urandom, $urandom}, int'($urandom % 3), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  unit can accept request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV64I load/store funct3.
REQ-009 SHALL have port req_addr  input  64  byte address.
REQ-010 SHALL have port req_wdata  input  WIDTH  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port resp_rdata  output  WIDTH  extended load data; 0 for stores and faults.
REQ-014 SHALL have port resp_err  output  1  request faulted.
REQ-015 SHALL have port resp_cause  output  2  0 none, 1 misaligned, 2 illegal funct3, 3 out of range.
REQ-016 SHALL have port mem_addr  output  ADDR_WIDTH  word address to memory.
REQ-017 SHALL have port mem_wdata  output  WIDTH  lane-shifted store data.
REQ-018 SHALL have port mem_we  output  WIDTH/8  per-byte write enables.
REQ-019 SHALL have port mem_re  output  1  read enable.
REQ-020 SHALL have port mem_rdata  input  WIDTH  memory read data, valid the cycle after mem_re is sampled.

Function
REQ-021 SHALL implement states IDLE, STORE, LOAD, LWAIT, RESP; req_ready = 1 only in IDLE.
REQ-022 SHALL latch request on req_valid && req_ready; fault check uses latched fields.
REQ-023 SHALL detect faults in priority: illegal funct3 (load 111, store 1xx) > misaligned (H: addr[0]; W: addr[1:0]; D: addr[2:0] nonzero) > out of range (addr[63:ADDR_WIDTH+3] nonzero).
REQ-024 SHALL on fault go IDLE->RESP directly, never asserting mem_re or mem_we; resp_valid at accept+1.
REQ-025 SHALL in STORE drive mem_addr = addr[ADDR_WIDTH+2:3], mem_wdata = wdata << 8*addr[2:0], mem_we = {SB 8'h01, SH 8'h03, SW 8'h0F, SD 8'hFF} << addr[2:0], for exactly one cycle; resp_valid at accept+2.
REQ-026 SHALL in LOAD assert mem_re for exactly one cycle with mem_addr as REQ-025; in LWAIT capture mem_rdata >> 8*addr[2:0], sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU), LD unchanged; resp_valid at accept+3.
REQ-027 SHALL hold resp_valid, resp_rdata, resp_err, resp_cause stable in RESP until resp_ready; RESP->IDLE on resp_valid && resp_ready.
REQ-028 SHALL keep mem_we = 0 and mem_re = 0 outside STORE and LOAD respectively; mem_wdata/mem_addr = 0 when idle.
REQ-029 SHALL ignore req_valid outside IDLE (no queuing); back-to-back accept possible the cycle after RESP handshake.

Reset
REQ-030 SHALL on rst low immediately force state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, resp_cause 0, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0.
REQ-031 SHALL abandon any in-flight request on reset; a store whose STORE cycle overlaps reset SHALL NOT be committed (mem_we low at that edge).

Structure
REQ-032 SHALL place funct3 encodings, resp_cause codes and the state enum in shared package lsu_pkg.
REQ-033 SHALL implement the combinational lane-shift and sign/zero-extend in sub-module lsu_load_extend.

Verification (memory preloaded: word0 = 64'hDEADBEEF12345678, word1 = 64'hCAFEBABE87654321)
REQ-034 SHALL cover: SB addr 0x5 wdata 0xAA -> mem_addr 0, mem_we 8'h20, mem_wdata[47:40] 0xAA for one cycle, resp_valid at accept+2, resp_err 0.
REQ-035 SHALL cover: LB addr 0x4 -> resp_rdata 64'hFFFFFFFFFFFFFFEF at accept+3; LBU addr 0x4 -> 64'h00000000000000EF.
REQ-036 SHALL cover: LW addr 0xC -> 64'hFFFFFFFFCAFEBABE; LWU addr 0xC -> 64'h00000000CAFEBABE; LD addr 0x8 -> 64'hCAFEBABE87654321.
REQ-037 SHALL cover: LH addr 0x3 -> resp_err 1, cause 1, resp_valid at accept+1, mem_re/mem_we never asserted; load funct3 111 -> cause 2; SD addr 0x2000 -> cause 3.
REQ-038 SHALL cover: resp_ready low 3 cycles after LD -> resp_valid and resp_rdata stable, req_ready 0, new req_valid ignored.
REQ-039 SHALL cover: rst low during STORE cycle of SD addr 0x0 wdata all-ones -> mem_we 0 immediately, word0 unchanged, all outputs at REQ-030 values.
